// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO behind a UART receiver. It captures
// {stop_err, parity_err, data} on each rising edge of rx_valid.
// Ports: clk, rst (async active-low); rx_data/rx_parity_error/
// rx_stop_error/rx_valid from the receiver; rd_en -> rd_data/rd_perr/
// rd_serr/rd_valid registered read port; empty/full/count occupancy;
// overflow sticky (ovf_clr clears); err_cnt saturating error count.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter bit DROP_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_parity_error,
    input  logic          rx_stop_error,
    input  logic          rx_valid,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          rd_serr,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    err_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic          rx_valid_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    mem [DEPTH];

    logic          wr_req;
    logic          err_flag;
    logic          wr_try;
    logic          wr_ok;
    logic          rd_ok;
    logic          ovf_ev;
    logic [AW:0]   count_nxt;

    assign wr_req   = rx_valid & ~rx_valid_d;
    assign err_flag = rx_parity_error | rx_stop_error;
    // A frame that survives the error filter and wants a slot.
    assign wr_try   = wr_req & ~(DROP_ERR & err_flag);
    assign rd_ok    = rd_en & ~empty;
    // A read in the same cycle frees the slot the write needs.
    assign wr_ok    = wr_try & (~full | rd_ok);
    assign ovf_ev   = wr_try & full & ~rd_ok;

    always_comb begin
        count_nxt = count;
        if (wr_ok & ~rd_ok)
            count_nxt = count + ONE;
        else if (rd_ok & ~wr_ok)
            count_nxt = count - ONE;
    end

    // Storage is not reset; occupancy tracking makes stale data unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {rx_stop_error, rx_parity_error, rx_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_d <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            err_cnt    <= '0;
            rd_data    <= '0;
            rd_perr    <= 1'b0;
            rd_serr    <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rx_valid_d <= rx_valid;
            count      <= count_nxt;
            empty      <= (count_nxt == '0);
            full       <= (count_nxt == FULL_CNT);
            rd_valid   <= rd_ok;

            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;

            // Read uses the pre-edge array word, so a read and write
            // to the same slot when full returns the older entry.
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr][7:0];
                rd_perr <= mem[rd_ptr][8];
                rd_serr <= mem[rd_ptr][9];
            end

            if (ovf_ev)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (wr_req & err_flag & (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: random and directed stimulus for uart_rx_fifo, with
// DROP_ERR=0 and DROP_ERR=1 instances checked against a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       pe;
    logic       se;
    logic       rx_valid;
    logic       rd_en;
    logic       ovf_clr;

    logic [7:0] o_rd_data [2];
    logic       o_rd_perr [2];
    logic       o_rd_serr [2];
    logic       o_rd_valid[2];
    logic       o_empty   [2];
    logic       o_full    [2];
    logic [4:0] o_count   [2];
    logic       o_ovf     [2];
    logic [7:0] o_err_cnt [2];

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4), .DROP_ERR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rx_parity_error(pe), .rx_stop_error(se),
        .rx_valid(rx_valid), .rd_en(rd_en),
        .rd_data(o_rd_data[0]), .rd_perr(o_rd_perr[0]),
        .rd_serr(o_rd_serr[0]), .rd_valid(o_rd_valid[0]),
        .empty(o_empty[0]), .full(o_full[0]), .count(o_count[0]),
        .overflow(o_ovf[0]), .ovf_clr(ovf_clr), .err_cnt(o_err_cnt[0])
    );

    uart_rx_fifo #(.DEPTH(16), .AW(4), .DROP_ERR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rx_parity_error(pe), .rx_stop_error(se),
        .rx_valid(rx_valid), .rd_en(rd_en),
        .rd_data(o_rd_data[1]), .rd_perr(o_rd_perr[1]),
        .rd_serr(o_rd_serr[1]), .rd_valid(o_rd_valid[1]),
        .empty(o_empty[1]), .full(o_full[1]), .count(o_count[1]),
        .overflow(o_ovf[1]), .ovf_clr(ovf_clr), .err_cnt(o_err_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one queue of 10-bit frames per instance.
    logic [9:0] mq [2][$];
    bit         m_pv [2] = '{1'b1, 1'b1};
    bit         m_ovf[2] = '{1'b0, 1'b0};
    int         m_ec [2] = '{0, 0};
    bit         m_rv [2] = '{1'b0, 1'b0};
    logic [9:0] m_rw [2] = '{10'd0, 10'd0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_pv[i] = 1'b1;
                m_ovf[i] = 1'b0;
                m_ec[i] = 0;
                m_rv[i] = 1'b0;
                m_rw[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit wreq;
                bit ef;
                bit rok;
                bit keep;
                int sz;
                wreq = rx_valid && !m_pv[i];
                m_pv[i] = rx_valid;
                ef = pe || se;
                keep = !(i == 1 && ef);
                sz = mq[i].size();
                if (wreq && ef && m_ec[i] < 255)
                    m_ec[i]++;
                rok = rd_en && sz > 0;
                m_rv[i] = rok;
                if (rok)
                    m_rw[i] = mq[i].pop_front();
                if (wreq && keep) begin
                    if (sz < DEPTH || rok)
                        mq[i].push_back({se, pe, rx_data});
                    else
                        m_ovf[i] = 1'b1;
                end
                if (!(wreq && keep && sz == DEPTH && !rok) && ovf_clr)
                    m_ovf[i] = 1'b0;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            chk($sformatf("d%0d.count", i), 32'(o_count[i]), 32'(sz));
            chk($sformatf("d%0d.empty", i), 32'(o_empty[i]), 32'(sz == 0));
            chk($sformatf("d%0d.full", i), 32'(o_full[i]), 32'(sz == DEPTH));
            chk($sformatf("d%0d.rd_valid", i), 32'(o_rd_valid[i]),
                32'(m_rv[i]));
            chk($sformatf("d%0d.rd_data", i), 32'(o_rd_data[i]),
                32'(m_rw[i][7:0]));
            chk($sformatf("d%0d.rd_perr", i), 32'(o_rd_perr[i]),
                32'(m_rw[i][8]));
            chk($sformatf("d%0d.rd_serr", i), 32'(o_rd_serr[i]),
                32'(m_rw[i][9]));
            chk($sformatf("d%0d.overflow", i), 32'(o_ovf[i]),
                32'(m_ovf[i]));
            chk($sformatf("d%0d.err_cnt", i), 32'(o_err_cnt[i]),
                32'(m_ec[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic s);
        rx_data = d;
        pe = p;
        se = s;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        pe = 1'b0;
        se = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input string n, input logic [7:0] e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({n, ".v"}, 32'(o_rd_valid[0]), 32'd1);
        chk({n, ".d"}, 32'(o_rd_data[0]), 32'(e));
    endtask

    initial begin
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        pe = 1'b0;
        se = 1'b0;
        rd_en = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst.count", 32'(o_count[0]), 32'd0);
        chk("rst.empty", 32'(o_empty[0]), 32'd1);
        chk("rst.full", 32'(o_full[0]), 32'd0);
        rst = 1'b1;
        tick();

        // Basic order
        push(8'hDD, 0, 0);
        push(8'hD2, 0, 0);
        push(8'hD0, 0, 0);
        push(8'hD5, 0, 0);
        chk("basic.count4", 32'(o_count[0]), 32'd4);
        rd_chk("basic.r0", 8'hDD);
        rd_chk("basic.r1", 8'hD2);
        rd_chk("basic.r2", 8'hD0);
        rd_chk("basic.r3", 8'hD5);
        chk("basic.empty", 32'(o_empty[0]), 32'd1);
        chk("basic.count0", 32'(o_count[0]), 32'd0);

        // Level vs edge
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        repeat (20) tick();
        rx_valid = 1'b0;
        tick();
        chk("level.count", 32'(o_count[0]), 32'd1);
        rd_chk("level.rd", 8'hA5);

        // Full and overflow
        for (int i = 0; i < 16; i++)
            push(8'(i), 0, 0);
        chk("full.full", 32'(o_full[0]), 32'd1);
        push(8'h10, 0, 0);
        chk("full.ovf", 32'(o_ovf[0]), 32'd1);
        chk("full.count", 32'(o_count[0]), 32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("full.ovf_clr", 32'(o_ovf[0]), 32'd0);

        // Read and write together while full
        rx_data = 8'h77;
        rx_valid = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en = 1'b0;
        chk("simf.rd", 32'(o_rd_data[0]), 32'h00);
        chk("simf.count", 32'(o_count[0]), 32'd16);
        chk("simf.ovf", 32'(o_ovf[0]), 32'd0);
        tick();
        for (int i = 1; i < 16; i++)
            rd_chk($sformatf("drain%0d", i), 8'(i));
        rd_chk("drain.last", 8'h77);
        chk("drain.empty", 32'(o_empty[0]), 32'd1);

        // Read and write together while empty
        rx_data = 8'h33;
        rx_valid = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en = 1'b0;
        chk("sime.rv", 32'(o_rd_valid[0]), 32'd0);
        chk("sime.count", 32'(o_count[0]), 32'd1);
        tick();
        rd_chk("sime.rd", 8'h33);

        // Error frames
        push(8'h5A, 1, 0);
        push(8'h3C, 0, 1);
        chk("err.count0", 32'(o_count[0]), 32'd2);
        chk("err.cnt0", 32'(o_err_cnt[0]), 32'd2);
        chk("err.empty1", 32'(o_empty[1]), 32'd1);
        chk("err.cnt1", 32'(o_err_cnt[1]), 32'd2);
        rd_en = 1'b1;
        tick();
        chk("err.d0", 32'(o_rd_data[0]), 32'h5A);
        chk("err.p0", 32'(o_rd_perr[0]), 32'd1);
        chk("err.s0", 32'(o_rd_serr[0]), 32'd0);
        tick();
        rd_en = 1'b0;
        chk("err.d1", 32'(o_rd_data[0]), 32'h3C);
        chk("err.p1", 32'(o_rd_perr[0]), 32'd0);
        chk("err.s1", 32'(o_rd_serr[0]), 32'd1);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            rx_valid = ($urandom % 3) == 0;
            rx_data = 8'($urandom);
            pe = ($urandom % 8) == 0;
            se = ($urandom % 8) == 0;
            rd_en = (c < 1000) ? (($urandom % 5) == 0)
                               : (($urandom % 2) == 0);
            ovf_clr = ($urandom % 50) == 0;
            tick();
        end
        rx_valid = 1'b0;
        pe = 1'b0;
        se = 1'b0;
        rd_en = 1'b0;
        ovf_clr = 1'b0;
        tick();

        // Error counter saturation
        repeat (300) push(8'h11, 1, 1);
        chk("sat.cnt0", 32'(o_err_cnt[0]), 32'hFF);
        chk("sat.cnt1", 32'(o_err_cnt[1]), 32'hFF);

        // Reset in the middle of a read
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++)
            push(8'hE0 + 8'(i), 0, 0);
        chk("mid.count5", 32'(o_count[0]), 32'd5);
        rd_en = 1'b1;
        #3;
        rst = 1'b0;
        rx_valid = 1'b1;
        #1;
        chk("mid.count", 32'(o_count[0]), 32'd0);
        chk("mid.empty", 32'(o_empty[0]), 32'd1);
        chk("mid.rv", 32'(o_rd_valid[0]), 32'd0);
        chk("mid.rd", 32'(o_rd_data[0]), 32'd0);
        chk("mid.ovf", 32'(o_ovf[0]), 32'd0);
        chk("mid.err", 32'(o_err_cnt[0]), 32'd0);
        rd_en = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post.count", 32'(o_count[0]), 32'd0);
        rx_valid = 1'b0;
        tick();
        push(8'h42, 0, 0);
        chk("post.count1", 32'(o_count[0]), 32'd1);
        rd_chk("post.rd", 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte together with its parity and stop error flags on the rising edge of the receiver's `op_valid`. Frames are stored in a circular FIFO, and the consumer reads them back through a registered read port. Overflow and error events are tracked so software can see lost or corrupted frames.

## Interface
- `DEPTH`, 16: number of FIFO entries. Must be a power of 2, at least 2.
- `AW`, 4: address width. Must equal log2(`DEPTH`).
- `DROP_ERR`, 0: 1 = frames with any error flag are discarded instead of stored (still counted).

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from the UART receiver (`DATA_out`).
- `rx_parity_error`  in  1  parity error flag for `rx_data`.
- `rx_stop_error`  in  1  stop-bit error flag for `rx_data`.
- `rx_valid`  in  1  receiver `op_valid`, a level signal; a frame is its rising edge.
- `rd_en`  in  1  read request.
- `rd_data`  out  8  byte read.
- `rd_perr`  out  1  stored parity error of the read byte.
- `rd_serr`  out  1  stored stop error of the read byte.
- `rd_valid`  out  1  one-cycle pulse; `rd_*` outputs are valid this cycle.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky flag: a frame was lost because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.
- `err_cnt`  out  8  count of frames with any error, saturates at 255.

## Operation
- Edge detect: register `rx_valid_d`; `wr_req = rx_valid & ~rx_valid_d`.
  - `rx_valid_d` resets to 1, so a frame already asserted at reset release is not captured.
- Storage: 10-bit entry {`rx_stop_error`, `rx_parity_error`, `rx_data`}, sampled on the same edge as `wr_req`.
- Error tracking: `err_flag = rx_parity_error | rx_stop_error`.
  - Every `wr_req` with `err_flag` increments `err_cnt` (saturating), regardless of `DROP_ERR` or fullness.
  - `DROP_ERR`=1 and `err_flag`: the frame is not written, and the write pointer and `count` are unchanged.
- Write accept: `wr_ok = wr_req & ~(DROP_ERR & err_flag) & (~full | rd_ok)`.
- Overflow: `wr_req & ~(DROP_ERR & err_flag) & full & ~rd_ok` drops the frame and sets `overflow`.
- Read accept: `rd_ok = rd_en & ~empty`.
  - The entry at the read pointer loads into `rd_data`/`rd_perr`/`rd_serr`.
  - The read pointer increments.
  - `rd_en` while empty is ignored: no pointer change, no `rd_valid`.
- Pointers: `AW`-bit write and read pointers, wrapping from `DEPTH`-1 to 0.
- `count` update:
  - +1 on `wr_ok` only.
  - −1 on `rd_ok` only.
  - unchanged when both occur.
- Flags: `empty` = (`count`==0); `full` = (`count`==`DEPTH`). Both are registered, consistent with `count`.
- Simultaneous read and write:
  - When full: both are accepted, no overflow, `count` stays at `DEPTH`.
  - When empty: `rd_en` is ignored and the write is accepted; `count` becomes 1.
- `overflow`: cleared by `ovf_clr`. If `ovf_clr` and a new overflow event occur in the same cycle, set wins.

## Timing
- Write latency: a byte captured at edge N is reflected in `count`/`empty` after edge N, and can be read with `rd_en` at edge N+1.
- Read latency: `rd_en` sampled at edge N gives `rd_valid`=1 and valid `rd_*` after edge N.
  - `rd_valid` is high for exactly one cycle.
  - `rd_data`/`rd_perr`/`rd_serr` hold their value until the next read.
- Back-to-back `rd_en` every cycle drains one entry per cycle.
- Reset (asynchronous assert, any time, including mid-frame or mid-read):
  - pointers = 0, `count` = 0, `empty` = 1, `full` = 0.
  - `overflow` = 0, `err_cnt` = 0.
  - `rd_data` = 0, `rd_perr` = 0, `rd_serr` = 0, `rd_valid` = 0, `rx_valid_d` = 1.
  - All stored contents are discarded.
- Memory array contents need no reset.

## Test plan
- Basic order: pulses of `rx_valid` carrying 0xDD, 0xD2, 0xD0, 0xD5, no errors, then four reads → `rd_data` = DD, D2, D0, D5 in order. `count` goes 4→0; `empty`=1 after the last read.
- Level vs edge: `rx_valid` held high 20 cycles with 0xA5 → exactly one entry stored, `count`=1.
- Full/overflow (`DEPTH`=16): write 0x00..0x0F, then 0x10 → `full`=1, `overflow`=1, 0x10 is lost. Draining returns 0x00..0x0F. Pulse `ovf_clr` → `overflow`=0.
- Simultaneous events:
  - When full, `rd_en` and a write of 0x77 in the same cycle → `count` stays 16, no overflow; 0x77 is read last.
  - When empty, `rd_en` and a write of 0x33 in the same cycle → `rd_valid`=0, `count`=1.
- Errors: 0x5A with `rx_parity_error`=1, then 0x3C with `rx_stop_error`=1.
  - `DROP_ERR`=0: both are stored, with `rd_perr`=1 / `rd_serr`=1 respectively; `err_cnt`=2.
  - `DROP_ERR`=1: nothing is stored, `empty`=1; `err_cnt`=2.
- Reset mid-operation: with 5 entries stored and `rd_en` high, assert `rst`=0 between clock edges → outputs return to reset values immediately. After release, an `rx_valid` already high is not captured.
